// File: rtl/seq_multiplier32_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_multiplier32_if : start/busy/done handshake and operand/result bus   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface seq_multiplier32_if;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/seq_multiplier32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_multiplier32 : 32x32->64 unsigned shift-and-add multiplier, 32 iters |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module adder32 (
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        cout
);
  logic [8:0] part;
  logic       carry;

  // Four 8-bit ripple stages, carry chained through a local variable.
  always_comb begin
    sum   = '0;
    part  = '0;
    carry = carry_in;
    for (int i = 0; i < 4; i++) begin
      part           = {1'b0, operand1[8*i +: 8]} + {1'b0, operand2[8*i +: 8]} + {8'b0, carry};
      sum[8*i +: 8]  = part[7:0];
      carry          = part[8];
    end
    cout = carry;
  end
endmodule

module seq_multiplier32 (
  input  logic               clk,
  input  logic               rst,
  seq_multiplier32_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'd31;

  state_t      state;
  state_t      next_state;
  logic [31:0] mcand;
  logic [64:0] acc;
  logic [64:0] acc_next;
  logic [5:0]  cnt;
  logic [63:0] product_q;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        accept;
  logic        busy;
  logic        done;

  adder32 u_adder (
    .operand1 (acc[63:32]),
    .operand2 (mcand),
    .carry_in (1'b0),
    .sum      (add_sum),
    .cout     (add_cout)
  );

  // Carry is kept as bit 64 ahead of the shift so no partial-product bit is lost.
  always_comb begin
    if (acc[0])
      acc_next = {add_cout, add_sum, acc[31:0]} >> 1;
    else
      acc_next = {1'b0, acc[63:0]} >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.start;
        if (bus.start)
          next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_ITER)
          next_state = DONE;
      end
      DONE: begin
        done   = 1'b1;
        accept = bus.start;
        next_state = bus.start ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand <= bus.multiplicand;
      acc   <= {33'b0, bus.multiplier};
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      cnt <= cnt + 6'd1;
      if (cnt == LAST_ITER)
        product_q <= acc_next[63:0];
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_q;
endmodule
`default_nettype wire

// File: doc/seq_multiplier32.md
# seq_multiplier32

Iterative 32×32→64 unsigned shift-and-add multiplier that consumes the 32-bit ripple adder (`Adder32`, carry_in tied 0) once per cycle. It sits downstream of the adder in the ALU/datapath: it feeds the adder the upper partial-product word and the multiplicand, then registers the sum and carry. A start/busy/done handshake gives the datapath a fixed-latency multiply without a combinational array.

## Interface
- No parameters. Operand width is fixed at 32 to match the 32-bit adder.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled on a rising edge while `busy`=0.
- `multiplicand` input 32: operand A, captured on the accepting edge.
- `multiplier` input 32: operand B, captured on the accepting edge.
- `busy` output 1: high while a multiply is in progress (RUN state).
- `done` output 1: one-cycle pulse marking `product` as updated.
- `product` output 64: registered result, A×B unsigned.

## Operation
- Internal registers:
  - `mcand[31:0]`.
  - `acc[64:0]` = {carry, hi[31:0], lo[31:0]}.
  - `cnt[5:0]`.
  - `state` ∈ {IDLE, RUN, DONE}.
  - `product_q[63:0]`.
- Adder hookup: operand1 = acc[63:32], operand2 = mcand, carry_in = 0 → sum[31:0], cout.
- IDLE:
  - `busy`=0, `done`=0.
  - On `start`=1: mcand←multiplicand, acc←{1'b0, 32'b0, multiplier}, cnt←0, go to RUN.
- RUN, one iteration per cycle:
  - If acc[0]=1: acc ← {cout, sum, acc[31:0]} >> 1.
  - Else: acc ← {1'b0, acc[63:0]} >> 1.
  - cnt←cnt+1.
  - When cnt=31 on this edge (32nd iteration): product_q ← the shifted acc[63:0], go to DONE.
- DONE:
  - `done`=1, `busy`=0, for exactly one cycle.
  - On `start`=1: accept new operands exactly as in IDLE and go to RUN.
  - Otherwise go to IDLE.
- `start` while in RUN is ignored; operands are not resampled.
- `product` = product_q. It changes only on the edge entering DONE and holds until the next completion, so it is stable during a following RUN.
- Arithmetic:
  - Unsigned only.
  - The carry-out of every add is kept as bit 64 before the shift, so no partial-product bit is lost.
  - The result is exact for all operand pairs; the maximum is 0xFFFFFFFE_00000001.
- Reset (asynchronous, any state, including mid-RUN):
  - state←IDLE, cnt←0, acc←0, mcand←0, product_q←0.
  - `busy`=0, `done`=0, `product`=0 immediately; the in-flight operation is discarded.
  - After reset is released, the first accepted `start` starts a fresh multiply.

## Timing
- Edge E0 samples `start`=1 in IDLE/DONE. After E0: `busy`=1.
- Edges E1..E32 perform the 32 iterations.
- After E32:
  - state=DONE, `busy`=0, `done`=1.
  - `product` is valid.
- Latency is 32 cycles from the accepting edge to the `done` edge, with `done` visible in the 33rd cycle.
- After E33: `done`=0.
- Back-to-back operation: `start` held during the DONE cycle is accepted at E33. Throughput is one multiply per 33 cycles.
- `start` must be valid before the rising edge. Operand inputs are don't-care except on the accepting edge.
- The adder path is combinational within one cycle: the 4×8-bit ripple plus the shift mux must meet the clock period.
- Outputs `busy`, `done` and `product` are all registered or decoded from state. No input→output combinational path.

## Test plan
- Reset release, then A=3, B=5, `start` for 1 cycle:
  - `busy`=1 for 32 cycles.
  - `done` pulses once at cycle 33.
  - `product`=0x0000_0000_0000_000F.
- A=0xFFFF_FFFF, B=0xFFFF_FFFF: `product`=0xFFFF_FFFE_0000_0001, which exercises cout capture on every iteration.
- A=0x1234_5678, B=0:
  - `product`=0.
  - A=0, B=0xDEAD_BEEF: `product`=0.
  - Latency is still 32 cycles.
- Start A=7, B=9, then pulse `start` with A=2, B=2 at cycle 10 of RUN:
  - The second request is ignored.
  - `product`=63.
  - Exactly one `done` pulse.
- Start A=0x8000_0000, B=2, then assert `rst` at cycle 16:
  - `busy`, `done` and `product` go to 0 immediately.
  - After release, A=6, B=7 yields 42 with full 32-cycle latency.
- Back-to-back: A=10, B=10, then hold `start` through the DONE cycle with A=0x1_0000, B=0x1_0000:
  - `done` pulses, `product`=100.
  - The second op starts at E33 with no IDLE gap.
  - Next `done` after 33 cycles with `product`=0x0000_0001_0000_0000.
  - `product` stays 100 during the second RUN.
